mem_port_arbiter: RTL and testbench

- Shares one single-port 128x32 memory between three requesters: the preload/loader port (writes only), the data-memory stage (load/store) and the instruction-fetch stage (reads only).
- Lets the pipeline run from a unified memory instead of separate instruction and data arrays.
- Sequences each access through a grant/latency/response FSM against a memory with fixed read latency.
- Fetch and memory stages stall on their own request until the arbiter answers.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
//   state_e : arbiter FSM states (IDLE, GRANT, WAIT, RESP)
//   OWN_*   : one-hot owner encoding (loader, data stage, fetch stage)
//   ADDR_W_DEF / DATA_W_DEF : default memory geometry (128 x 32)
//   CNT_W   : width of the read-latency counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [2:0] OWN_NONE = 3'b000;
  localparam logic [2:0] OWN_LD   = 3'b001;
  localparam logic [2:0] OWN_DM   = 3'b010;
  localparam logic [2:0] OWN_IF   = 3'b100;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority picker for the memory port arbiter.
// Ports:
//   ld_req_i     loader request (always highest priority)
//   dm_req_i     data-stage request
//   if_req_i     fetch request
//   starve_ovr_i lets fetch outrank the data stage for this arbitration
//   own_o        one-hot winner (OWN_LD / OWN_DM / OWN_IF), OWN_NONE if idle
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       ld_req_i,
  input  logic       dm_req_i,
  input  logic       if_req_i,
  input  logic       starve_ovr_i,
  output logic [2:0] own_o
);

  // Loader always wins; the override only reorders data vs fetch.
  always_comb begin
    own_o = OWN_NONE;
    if (ld_req_i) begin
      own_o = OWN_LD;
    end else if (if_req_i && (starve_ovr_i || !dm_req_i)) begin
      own_o = OWN_IF;
    end else if (dm_req_i) begin
      own_o = OWN_DM;
    end else begin
      own_o = OWN_NONE;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory with fixed read latency between the loader
// (writes), the data stage (loads/stores) and the fetch stage (reads).
// Each access runs IDLE -> GRANT -> (WAIT -> RESP) -> IDLE; all outputs
// are registered.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ld_req/ld_addr/ld_wdata/ld_gnt  loader write port
//   dm_req/dm_we/dm_addr/dm_wdata   data-stage request
//   dm_gnt/dm_rvalid/dm_rdata       data-stage grant and load response
//   if_req/if_addr                  fetch request
//   if_gnt/if_rvalid/if_rdata       fetch grant and response
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory interface
//   busy                            FSM is not in IDLE
// Optional build macro MEM_ARB_STARVE_GUARD_EN: after MAX_WAIT lost
// arbitrations in a row, fetch outranks the data stage (never the loader).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = 4'd1;

  state_e            state_q;
  logic [2:0]        own_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ld_gnt_q, dm_gnt_q, if_gnt_q;
  logic              dm_rvalid_q, if_rvalid_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, dm_rdata_q, if_rdata_q;
  logic [2:0]        pick_s;
  logic              starve_ovr_s;

  mem_arb_pick u_pick (
    .ld_req_i     (ld_req),
    .dm_req_i     (dm_req),
    .if_req_i     (if_req),
    .starve_ovr_i (starve_ovr_s),
    .own_o        (pick_s)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  logic [7:0] starve_q;

  // Count consecutive IDLE arbitrations that fetch loses; saturates so the
  // override stays armed while the loader keeps winning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 8'd0;
    end else if (!if_req || (state_q == IDLE && pick_s == OWN_IF)) begin
      starve_q <= 8'd0;
    end else if (state_q == IDLE && starve_q != MAX_WAIT_C) begin
      starve_q <= starve_q + 8'd1;
    end else begin
      starve_q <= starve_q;
    end
  end

  assign starve_ovr_s = (starve_q == MAX_WAIT_C);
`else
  assign starve_ovr_s = 1'b0;
`endif

  // Arbiter FSM with registered grant/strobe/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      own_q       <= OWN_NONE;
      cnt_q       <= {CNT_W{1'b0}};
      ld_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_gnt_q    <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rvalid_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      dm_rdata_q  <= {DATA_W{1'b0}};
      if_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      // Pulse outputs fall back to 0 unless a state below raises them.
      ld_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_gnt_q    <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rvalid_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_s != OWN_NONE) begin
            own_q    <= pick_s;
            mem_en_q <= 1'b1;
            state_q  <= GRANT;
            case (pick_s)
              OWN_LD: begin
                ld_gnt_q    <= 1'b1;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= ld_addr;
                mem_wdata_q <= ld_wdata;
              end
              OWN_DM: begin
                dm_gnt_q    <= 1'b1;
                mem_we_q    <= dm_we;
                mem_addr_q  <= dm_addr;
                mem_wdata_q <= dm_wdata;
              end
              default: begin
                if_gnt_q   <= 1'b1;
                mem_addr_q <= if_addr;
              end
            endcase
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          // mem_we_q still holds this access's direction during GRANT.
          if (mem_we_q) begin
            state_q <= IDLE;
          end else begin
            state_q <= WAIT;
            cnt_q   <= LAT_C;
          end
        end
        WAIT: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= RESP;
            cnt_q   <= {CNT_W{1'b0}};
            if (own_q == OWN_DM) begin
              dm_rdata_q  <= mem_rdata;
              dm_rvalid_q <= 1'b1;
            end else begin
              if_rdata_q  <= mem_rdata;
              if_rvalid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ld_gnt    = ld_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_gnt    = if_gnt_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory model, timestamp-based
// reference model with per-cycle compare, directed cases, random traffic.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_req = 1'b0;
  logic [6:0]  ld_addr = 7'd0;
  logic [31:0] ld_wdata = 32'd0;
  logic        ld_gnt;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [6:0]  dm_addr = 7'd0;
  logic [31:0] dm_wdata = 32'd0;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        if_req = 1'b0;
  logic [6:0]  if_addr = 7'd0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        mem_en, mem_we, busy;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(7), .DATA_W(32), .MEM_LAT(LAT), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory model: data valid LAT cycles after mem_en ----------
  logic [31:0] mem [0:127];
  logic        hv [0:LAT];
  logic [6:0]  ha [0:LAT];
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101);
    for (int i = 0; i <= LAT; i++) begin hv[i] = 1'b0; ha[i] = 7'd0; end
    mem_rdata = 32'hBAD0_0000;
    forever begin
      @(negedge clk);
      for (int i = LAT; i > 0; i--) begin hv[i] = hv[i-1]; ha[i] = ha[i-1]; end
      hv[0] = mem_en && !mem_we;
      ha[0] = mem_addr;
      if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
      mem_rdata = hv[LAT] ? mem[ha[LAT]] : (32'hBAD0_0000 | 32'($urandom_range(0, 65535)));
    end
  end

  // ---------------- reference model: timestamps per transaction --------------
  logic [31:0] mmem [0:127];
  int          cyc, next_idle, gnt_cyc, rv_cyc;
  logic [2:0]  gnt_own, rv_own, m_w;
  logic        e_we, m_ovr;
  logic [6:0]  e_addr;
  logic [31:0] e_wdata, rv_data;
`ifdef MEM_ARB_STARVE_GUARD_EN
  int          m_starve;
`endif
  initial begin
    for (int i = 0; i < 128; i++) mmem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101);
    cyc = 0; next_idle = 0; gnt_cyc = -1; rv_cyc = -1;
    gnt_own = 3'b000; rv_own = 3'b000; e_we = 1'b0; e_addr = 7'd0;
    e_wdata = 32'd0; rv_data = 32'd0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    m_starve = 0;
`endif
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        next_idle = cyc; gnt_cyc = -1; rv_cyc = -1;
`ifdef MEM_ARB_STARVE_GUARD_EN
        m_starve = 0;
`endif
      end else begin
        if (cyc >= next_idle && (ld_req || dm_req || if_req)) begin
          m_ovr = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
          m_ovr = (m_starve == MAXW);
`endif
          if (ld_req) m_w = 3'b001;
          else if (if_req && (!dm_req || m_ovr)) m_w = 3'b100;
          else m_w = 3'b010;
`ifdef MEM_ARB_STARVE_GUARD_EN
          if (if_req) m_starve = (m_w == 3'b100) ? 0 : ((m_starve < MAXW) ? m_starve + 1 : m_starve);
`endif
          gnt_cyc = cyc + 1;
          gnt_own = m_w;
          if (m_w == 3'b001) begin e_we = 1'b1; e_addr = ld_addr; e_wdata = ld_wdata; end
          else if (m_w == 3'b010) begin e_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata; end
          else begin e_we = 1'b0; e_addr = if_addr; end
          if (e_we) begin
            mmem[e_addr] = e_wdata;
            next_idle = cyc + 2;
          end else begin
            rv_cyc = cyc + 2 + LAT; rv_own = m_w; rv_data = mmem[e_addr];
            next_idle = cyc + 3 + LAT;
          end
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        if (!if_req) m_starve = 0;
`endif
        cyc++;
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------------
  logic [31:0] x_dm_rd = 32'd0, x_if_rd = 32'd0;
  logic [2:0]  c_g, c_rv;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        x_dm_rd = 32'd0; x_if_rd = 32'd0;
        check("rst_flags", 32'({ld_gnt, dm_gnt, if_gnt, dm_rvalid, if_rvalid, mem_en, mem_we, busy}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
      end else begin
        c_g  = (cyc == gnt_cyc) ? gnt_own : 3'b000;
        c_rv = (cyc == rv_cyc) ? rv_own : 3'b000;
        check("gnt", 32'({if_gnt, dm_gnt, ld_gnt}), 32'(c_g));
        check("mem_en", 32'(mem_en), 32'(c_g != 3'b000));
        check("mem_we", 32'(mem_we), 32'((c_g != 3'b000) && e_we));
        if (c_g != 3'b000) check("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (c_g != 3'b000 && e_we) check("mem_wdata", mem_wdata, e_wdata);
        if (c_rv[1]) x_dm_rd = rv_data;
        if (c_rv[2]) x_if_rd = rv_data;
        check("rvalid", 32'({if_rvalid, dm_rvalid}), 32'(c_rv[2:1]));
        check("dm_rdata", dm_rdata, x_dm_rd);
        check("if_rdata", if_rdata, x_if_rd);
        check("busy", 32'(busy), 32'(cyc < next_idle));
      end
    end
  end

  // ---------------- directed-run logging -------------------------------------
  logic [2:0]  lg_g   [0:31];
  logic        lg_en  [0:31];
  logic        lg_we  [0:31];
  logic [6:0]  lg_addr[0:31];
  logic [1:0]  lg_rv  [0:31];
  logic [31:0] lg_dmrd[0:31];
  logic [31:0] lg_ifrd[0:31];
  logic        lg_busy[0:31];
  logic        keep_dm = 1'b0;

  // Cycle 0 is the cycle in which the caller set the requests.
  task automatic run_log(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      lg_g[k] = {if_gnt, dm_gnt, ld_gnt}; lg_en[k] = mem_en; lg_we[k] = mem_we;
      lg_addr[k] = mem_addr; lg_rv[k] = {if_rvalid, dm_rvalid};
      lg_dmrd[k] = dm_rdata; lg_ifrd[k] = if_rdata; lg_busy[k] = busy;
      #1;
      if (ld_gnt) ld_req = 1'b0;
      if (dm_gnt && !keep_dm) dm_req = 1'b0;
      if (if_gnt) if_req = 1'b0;
    end
  endtask

  int cnt_a, cnt_b, first_if, dm_st, if_st;
  bit allow;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_mem_en", 32'(mem_en), 32'd0);
    check("reset_gnts", 32'({ld_gnt, dm_gnt, if_gnt}), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;

    // Preload word 5 through the loader port.
    ld_req = 1'b1; ld_addr = 7'd5; ld_wdata = 32'h2001_0003;
    run_log(3);
    check("pre_ld_gnt", 32'(lg_g[1]), 32'h1);
    check("pre_ld_we", 32'(lg_we[1]), 32'h1);

    // Single fetch.
    if_req = 1'b1; if_addr = 7'd5;
    run_log(6);
    check("f_gnt_c1", 32'(lg_g[1]), 32'h4);
    check("f_en_c1", 32'(lg_en[1]), 32'h1);
    check("f_we_c1", 32'(lg_we[1]), 32'h0);
    check("f_addr_c1", 32'(lg_addr[1]), 32'd5);
    check("f_rv_c3", 32'(lg_rv[3]), 32'h0);
    check("f_rv_c4", 32'(lg_rv[4]), 32'h2);
    check("f_rdata_c4", lg_ifrd[4], 32'h2001_0003);

    // Concurrent store and fetch of the same word.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 7'd9; dm_wdata = 32'h0000_DEAD;
    if_req = 1'b1; if_addr = 7'd9;
    run_log(8);
    check("sf_dm_gnt_c1", 32'(lg_g[1]), 32'h2);
    check("sf_we_c1", 32'(lg_we[1]), 32'h1);
    check("sf_if_gnt_c3", 32'(lg_g[3]), 32'h4);
    check("sf_mem9", mem[9], 32'h0000_DEAD);
    check("sf_rv_c6", 32'(lg_rv[6]), 32'h2);
    check("sf_rdata_c6", lg_ifrd[6], 32'h0000_DEAD);

    // Three-way contention: loader, data load, fetch.
    ld_req = 1'b1; ld_addr = 7'd20; ld_wdata = 32'h1111_2222;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 7'd5;
    if_req = 1'b1; if_addr = 7'd20;
    run_log(14);
    cnt_a = 0;
    for (int k = 1; k <= 14; k++) if ($countones(lg_g[k]) > 1) cnt_a++;
    check("p_ld_gnt_c1", 32'(lg_g[1]), 32'h1);
    check("p_dm_gnt_c3", 32'(lg_g[3]), 32'h2);
    check("p_dm_rv_c6", 32'(lg_rv[6]), 32'h1);
    check("p_dm_rdata_c6", lg_dmrd[6], 32'h2001_0003);
    check("p_if_gnt_c8", 32'(lg_g[8]), 32'h4);
    check("p_if_rv_c11", 32'(lg_rv[11]), 32'h2);
    check("p_if_rdata_c11", lg_ifrd[11], 32'h1111_2222);
    check("p_dm_rdata_kept", lg_dmrd[11], 32'h2001_0003);
    check("p_one_gnt", 32'(cnt_a), 32'd0);

    // Reset during the WAIT of a data load.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 7'd9;
    run_log(2);
    rst_n = 1'b0;
    #1;
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_flags", 32'({dm_gnt, dm_rvalid, mem_en, mem_we}), 32'd0);
    check("rr_addr", 32'(mem_addr), 32'd0);
    check("rr_dm_rdata", dm_rdata, 32'd0);
    check("rr_if_rdata", if_rdata, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    run_log(8);
    cnt_a = 0;
    for (int k = 1; k <= 8; k++) if (lg_rv[k] != 2'b00) cnt_a++;
    check("rr_no_rvalid", 32'(cnt_a), 32'd0);
    check("rr_idle", 32'(lg_busy[8]), 32'd0);

    // Back-to-back stores against a held fetch request.
    keep_dm = 1'b1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 7'd30; dm_wdata = 32'hCAFE_0001;
    if_req = 1'b1; if_addr = 7'd30;
    run_log(12);
    first_if = -1; cnt_b = 0;
    for (int k = 1; k <= 12; k++) begin
      if (lg_g[k][2] && first_if < 0) first_if = k;
      if (lg_g[k][1]) cnt_b++;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("sv_if_first", 32'(first_if), 32'd9);
    check("sv_dm_count", 32'(cnt_b), 32'd4);
`else
    check("sv_if_first", 32'(first_if), 32'hFFFF_FFFF);
    check("sv_dm_count", 32'(cnt_b), 32'd6);
`endif
    keep_dm = 1'b0; dm_req = 1'b0;
    run_log(10);

    // Random traffic; requesters obey the hold-until-grant protocol.
    dm_st = 0; if_st = 0;
    for (int c = 0; c < 900; c++) begin
      allow = (c < 850);
      @(negedge clk); #1;
      if (ld_req) begin
        if (ld_gnt) ld_req = 1'b0;
      end else if (allow && $urandom_range(0, 9) == 0) begin
        ld_req = 1'b1; ld_addr = 7'($urandom_range(0, 15)); ld_wdata = $urandom;
      end
      case (dm_st)
        1: if (dm_gnt) begin dm_req = 1'b0; dm_st = dm_we ? 0 : 2; end
        2: if (dm_rvalid) dm_st = 0;
        default: if (allow && $urandom_range(0, 3) == 0) begin
          dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
          dm_addr = 7'($urandom_range(0, 15)); dm_wdata = $urandom; dm_st = 1;
        end
      endcase
      case (if_st)
        1: if (if_gnt) begin if_req = 1'b0; if_st = 2; end
        2: if (if_rvalid) if_st = 0;
        default: if (allow && $urandom_range(0, 2) == 0) begin
          if_req = 1'b1; if_addr = 7'($urandom_range(0, 15)); if_st = 1;
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
